// File: rtl/add_16.sv
// 16-bit ripple-carry adder for the Hack datapath: combinational sum and flags,
// plus a registered copy for pipelined consumers.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module add_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        carry,
    output logic        ovf,
    output logic        zr,
    output logic        ng,
    output logic [15:0] out_q,
    output logic [3:0]  flags_q
);
    logic [15:0] sum;
    logic [15:0] c;
    logic [15:0] out_d;
    logic [3:0]  flags_d;

    half_adder u_ha0 (
        .a_i     (a[0]),
        .b_i     (b[0]),
        .sum_o   (sum[0]),
        .carry_o (c[0])
    );

    for (genvar i = 1; i < 16; i++) begin : g_fa
        full_adder u_fa (
            .a_i     (a[i]),
            .b_i     (b[i]),
            .c_i     (c[i-1]),
            .sum_o   (sum[i]),
            .carry_o (c[i])
        );
    end

    assign out   = sum;
    assign carry = c[15];
    // Signed wrap: operands agree in sign but the result does not.
    assign ovf   = (a[15] == b[15]) && (sum[15] != a[15]);
    assign zr    = (sum == 16'h0000);
    assign ng    = sum[15];

    assign out_d   = sum;
    assign flags_d = {carry, ovf, zr, ng};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= 16'h0000;
            flags_q <= 4'b0000;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_add_16.sv
// Directed and random checks of the add_16 combinational and registered paths.

module tb_add_16;
    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        carry;
    logic        ovf;
    logic        zr;
    logic        ng;
    logic [15:0] out_q;
    logic [3:0]  flags_q;

    int n_cmp = 0;
    int n_mis = 0;

    add_16 dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .out     (out),
        .carry   (carry),
        .ovf     (ovf),
        .zr      (zr),
        .ng      (ng),
        .out_q   (out_q),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Combinational vector: expected out and {carry, ovf, zr, ng} worked by hand.
    task automatic comb_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] exp_out, input logic [3:0] exp_flags);
        a = va;
        b = vb;
        #1;
        chk({tag, ".out"}, {16'h0, out}, {16'h0, exp_out});
        chk({tag, ".flags"}, {28'h0, carry, ovf, zr, ng}, {28'h0, exp_flags});
    endtask

    initial begin
        logic [16:0] s17;
        reset = 1'b1;
        a = 16'h0000;
        b = 16'h0000;

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s17 = {1'b0, a} + {1'b0, b};
            #1;
            chk("rand.sum", {15'h0, carry, out}, {15'h0, s17});
        end

        comb_vec("wrap",     16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        comb_vec("ovf_pos",  16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        comb_vec("ovf_neg",  16'h8000, 16'h8000, 16'h0000, 4'b1110);
        comb_vec("zero",     16'h0000, 16'h0000, 16'h0000, 4'b0010);
        comb_vec("ident",    16'h1234, 16'h0000, 16'h1234, 4'b0000);
        comb_vec("neg_nov",  16'hFFFE, 16'hFFFF, 16'hFFFD, 4'b1001);
        comb_vec("mixed",    16'h00F0, 16'h0F0F, 16'h0FFF, 4'b0000);
        comb_vec("carry_ch", 16'h5555, 16'hAAAB, 16'h0000, 4'b1010);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.out_q", {16'h0, out_q}, 32'h0);
        chk("rst.flags_q", {28'h0, flags_q}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        a = 16'h0003;
        b = 16'h0004;
        @(posedge clk);
        #1;
        chk("reg.out_q", {16'h0, out_q}, 32'h0007);
        chk("reg.flags_q", {28'h0, flags_q}, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        a = 16'h0010;
        b = 16'h0010;
        @(posedge clk);
        #1;
        chk("mid_rst.out_q", {16'h0, out_q}, 32'h0);
        chk("mid_rst.flags_q", {28'h0, flags_q}, 32'h0);
        chk("mid_rst.out", {16'h0, out}, 32'h0020);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.out_q", {16'h0, out_q}, 32'h0020);

        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0001;
        @(posedge clk);
        #1;
        chk("reg_wrap.out_q", {16'h0, out_q}, 32'h0);
        chk("reg_wrap.flags_q", {28'h0, flags_q}, 32'hA);

        @(negedge clk);
        a = 16'h8000;
        b = 16'h8000;
        @(posedge clk);
        #1;
        chk("reg_ovf.flags_q", {28'h0, flags_q}, 32'hE);

        @(negedge clk);
        a = 16'h7FFF;
        b = 16'h0001;
        @(posedge clk);
        #1;
        chk("reg_ng.out_q", {16'h0, out_q}, 32'h8000);
        chk("reg_ng.flags_q", {28'h0, flags_q}, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/add_16.md
# add_16

16-bit two's-complement/unsigned adder for the Hack datapath: a combinational sum `out = a + b` (mod 2^16), built as a ripple chain of full adders (half-adder/full-adder primitives, Hack style). A registered copy of the sum and flags is provided for pipelined consumers (ALU/PC-increment paths) on the single system clock. The combinational path is the primary function; the registered path is secondary.

## Interface
- No parameters; width fixed at 16.
- `clk`  input  1  system clock; all registers update on rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on rising `clk`.
- `a`  input  16  operand A.
- `b`  input  16  operand B.
- `out`  output  16  combinational sum, `(a + b) mod 65536`; carry out of bit 15 discarded.
- `carry`  output  1  combinational carry out of bit 15.
- `ovf`  output  1  combinational signed overflow: `a[15]==b[15] && out[15]!=a[15]`.
- `zr`  output  1  combinational zero flag: `out == 16'h0000`.
- `ng`  output  1  combinational negative flag: `out[15]`.
- `out_q`  output  16  registered `out`.
- `flags_q`  output  4  registered `{carry, ovf, zr, ng}`.

## Operation
- Sum: bit 0 uses a half adder (no carry-in); bits 1-15 use full adders, carry rippling from bit i to bit i+1; `carry` = carry out of bit 15.
- `out` must equal `a + b` truncated to 16 bits for every one of the 2^32 input pairs; no saturation.
- Unsigned and signed interpretations share the same `out`; `carry` flags unsigned wrap, `ovf` flags signed wrap.
- `zr`, `ng` derived from `out` only.
- Combinational outputs depend only on `a`, `b`; they ignore `clk` and `reset` entirely (valid even while `reset` is high or the clock is stopped).
- Registered path: on each rising `clk`, if `reset`=1 then `out_q`←0, `flags_q`←4'b0000; else `out_q`←`out`, `flags_q`←`{carry, ovf, zr, ng}`.
- No enables, no handshake; a new operand pair is accepted every cycle.

## Timing
- `out`, `carry`, `ovf`, `zr`, `ng`: zero-cycle latency; settled within 1 time unit of any input change in simulation (no inferred latches, no clocked elements in this path).
- `out_q`, `flags_q`: latency 1 cycle; reflect the `a`,`b` present at the preceding rising edge.
- Reset values: `out_q`=16'h0000, `flags_q`=4'b0000 (note: `zr` bit is 0 under reset even though value is 0). Combinational outputs have no reset value; they track inputs.
- Reset asserted mid-stream: the next rising edge clears registers; the first edge after deassertion captures the current sum.
- Before first reset, registered outputs are undefined (X in simulation).

## Test plan
- Random: 1000 iterations of `a=$random`, `b=$random`, wait 1 unit, require `out == a+b` (16-bit), reset held high, no clock edges needed.
- Wrap: `a=16'hFFFF, b=16'h0001` -> `out=16'h0000, carry=1, ovf=0, zr=1, ng=0`.
- Signed overflow: `a=16'h7FFF, b=16'h0001` -> `out=16'h8000, carry=0, ovf=1, ng=1`; `a=16'h8000, b=16'h8000` -> `out=0, carry=1, ovf=1, zr=1`.
- Zero/identity: `a=0, b=0` -> `out=0, zr=1`; `a=16'h1234, b=0` -> `out=16'h1234, zr=0`.
- Register path: hold `reset`=1 one edge -> `out_q=0, flags_q=0`; release, apply `a=16'h0003, b=16'h0004` -> after next edge `out_q=16'h0007, flags_q=4'b0000`.
- Reset mid-stream: registers loaded with `16'h0007`, assert `reset` one edge while `a=16'h0010, b=16'h0010` -> `out_q=0`, while `out=16'h0020` remains combinationally valid.
